fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage of the 5-stage LoongArch pipeline; the producer of the IF->ID bus and the consumer of the branch bus that ID drives.
- Issues PC-addressed reads on an SRAM-like instruction port with a req/addr_ok/data_ok handshake and at most one outstanding request.
- Buffers one returned instruction and hands {inst, pc} to ID under a valid/allowin handshake.
- Applies branch redirects and discards wrong-path fetches.

---
 rtl/fetch_stage_pkg.sv | 32 +++
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared IF/ID definitions: bus widths, reset PC and fetch FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FS_TO_DS_BUS_WD / BR_BUS_WD (also used by ID), RESET_PC_DEFAULT,
//           fs_state_e (S_REQ/S_WAIT/S_HOLD), br_bus_t and fs_to_ds_t layouts.
package fetch_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int BR_BUS_WD       = 34;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fs_state_e;

    // Branch bus driven by ID: only the cancel bit redirects fetch.
    typedef struct packed {
        logic        taken_cancel;
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    // IF->ID payload.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

endpackage

// File: rtl/fetch_stage_if.sv
// SRAM-like instruction port: req/addr_ok request phase, data_ok response phase.
// Latency: set by the memory; at most one request outstanding from IF.
// Backpressure: memory stalls a request by holding addr_ok low.
// Ports: master = fetch side (drives req/wr/size/wstrb/addr/wdata),
//        slave  = memory side (drives addr_ok/data_ok/rdata).
interface fetch_stage_if;

    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

endinterface

// File: rtl/fetch_stage.sv
// IF stage: fetches one instruction at a time over inst_sram and hands {inst, pc} to ID.
// Latency: REQ->WAIT->HOLD, 3 cycles/inst with zero-wait memory (2 with FS_BYPASS_EN).
// Backpressure: holds the buffered instruction while ds_allowin=0; no new request meanwhile.
// Ports: clk, reset (sync, active-high); ds_allowin, br_bus from ID;
//        fs_to_ds_valid/fs_to_ds_bus to ID; inst_sram (fetch_stage_if.master).
// Optional macro FS_BYPASS_EN: forward rdata straight to ID when data_ok meets ds_allowin.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    fetch_stage_if.master              inst_sram
);

    fs_state_e   r_state;
    logic [31:0] r_pc;
    logic        r_discard;     // outstanding response belongs to a wrong path
    logic        r_redir_pend;  // redirect seen while the request was still unaccepted
    logic [31:0] r_redir_tgt;
    fs_to_ds_t   r_inst_buf;

    br_bus_t     w_br;
    logic        w_redirect;
    logic        w_addr_ok;
    logic        w_data_ok;
    logic [31:0] w_rdata;
    logic        w_unused_br_taken;

    assign w_br       = br_bus;
    assign w_redirect = w_br.taken_cancel;
    assign w_addr_ok  = inst_sram.inst_sram_addr_ok;
    assign w_data_ok  = inst_sram.inst_sram_data_ok;
    assign w_rdata    = inst_sram.inst_sram_rdata;
    // A taken branch without cancel needs no action in IF.
    assign w_unused_br_taken = w_br.taken;

    // Request is decoded from state; reset gates it so nothing issues during reset.
    assign inst_sram.inst_sram_req   = (r_state == S_REQ) && !reset;
    assign inst_sram.inst_sram_addr  = r_pc;
    assign inst_sram.inst_sram_wr    = 1'b0;
    assign inst_sram.inst_sram_size  = 2'b10;
    assign inst_sram.inst_sram_wstrb = 4'b0000;
    assign inst_sram.inst_sram_wdata = 32'h0000_0000;

`ifdef FS_BYPASS_EN
    logic w_bypass;
    assign w_bypass = (r_state == S_WAIT) && w_data_ok && !r_discard && !w_redirect
                      && ds_allowin && !reset;
    assign fs_to_ds_valid = w_bypass || ((r_state == S_HOLD) && !w_redirect && !reset);
    assign fs_to_ds_bus   = w_bypass ? {w_rdata, r_pc} : r_inst_buf;
`else
    // A redirect in HOLD kills the buffered instruction in the same cycle.
    assign fs_to_ds_valid = (r_state == S_HOLD) && !w_redirect && !reset;
    assign fs_to_ds_bus   = r_inst_buf;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_discard    <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_tgt  <= 32'h0000_0000;
            r_inst_buf   <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_addr_ok) begin
                        r_state <= S_WAIT;
                        if (w_redirect) begin
                            // Newest target wins over any pending one.
                            r_discard    <= 1'b1;
                            r_pc         <= w_br.target;
                            r_redir_pend <= 1'b0;
                        end else if (r_redir_pend) begin
                            r_discard <= 1'b1;
                        end
                    end else if (w_redirect) begin
                        // Address must stay stable until accepted, so park the target.
                        r_redir_tgt  <= w_br.target;
                        r_redir_pend <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_data_ok) begin
                        r_discard <= 1'b0;
                        if (w_redirect) begin
                            r_pc         <= w_br.target;
                            r_redir_pend <= 1'b0;
                            r_state      <= S_REQ;
                        end else if (r_discard) begin
                            r_state <= S_REQ;
                            if (r_redir_pend) begin
                                r_pc         <= r_redir_tgt;
                                r_redir_pend <= 1'b0;
                            end
`ifdef FS_BYPASS_EN
                        end else if (ds_allowin) begin
                            r_pc    <= r_pc + 32'd4;
                            r_state <= S_REQ;
`endif
                        end else begin
                            r_inst_buf <= '{inst: w_rdata, pc: r_pc};
                            r_state    <= S_HOLD;
                        end
                    end else if (w_redirect) begin
                        r_discard    <= 1'b1;
                        r_pc         <= w_br.target;
                        r_redir_pend <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_br.target;
                        r_state <= S_REQ;
                    end else if (ds_allowin) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-table bench for fetch_stage with a behavioural instruction memory and an IF->ID scoreboard.
// Latency: n/a.
// Backpressure: ds_allowin and addr_ok are driven per table row.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] B  = 32'h1c00_0000;
    localparam logic [33:0] NB = 34'd0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ds_allowin = 1'b0;
    logic [33:0] br_bus = '0;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;

    fetch_stage_if sram_if();

    fetch_stage #(.RESET_PC(32'h1c00_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .inst_sram      (sram_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        alw;
        logic [33:0] br;
        logic        aok;
        int          dly;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } row_t;

    row_t        tbl[$];
    logic [63:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    logic        m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_cnt  = 0;

    function automatic logic [31:0] f_inst(input logic [31:0] a);
        return a ^ 32'h5eed_c0de;
    endfunction

    function automatic logic [33:0] rd(input logic [31:0] t);
        return {2'b11, t};
    endfunction

    task automatic check(input string nm, input int r, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, r, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic alw, input logic [33:0] br, input logic aok,
                       input int dly, input logic e_req, input logic [31:0] e_addr,
                       input logic e_vld, input logic [31:0] e_pc);
        row_t r;
        r.rst = rst; r.alw = alw; r.br = br; r.aok = aok; r.dly = dly;
        r.e_req = e_req; r.e_addr = e_addr; r.e_vld = e_vld; r.e_pc = e_pc;
        tbl.push_back(r);
    endtask

    task automatic r_rst();
        add(1'b1, 1'b0, NB, 1'b0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask
    task automatic r_req(input logic [31:0] a, input logic aok = 1'b1, input int dly = 0,
                         input logic [33:0] br = 34'd0);
        add(1'b0, 1'b1, br, aok, dly, 1'b1, a, 1'b0, 32'h0);
    endtask
    task automatic r_wait(input logic [33:0] br = 34'd0);
        add(1'b0, 1'b1, br, 1'b0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask
    task automatic r_hold(input logic [31:0] pc, input logic alw = 1'b1,
                          input logic [33:0] br = 34'd0, input logic vld = 1'b1);
        add(1'b0, alw, br, 1'b0, 0, 1'b0, 32'h0, vld, pc);
    endtask

    initial begin
        logic        d_ok;
        logic        req;
        logic [31:0] addr;
        logic [63:0] exp_bus;

        sram_if.inst_sram_addr_ok = 1'b0;
        sram_if.inst_sram_data_ok = 1'b0;
        sram_if.inst_sram_rdata   = 32'h0;

`ifdef FS_BYPASS_EN
        r_rst(); r_rst();
        for (int k = 0; k < 4; k++) begin
            r_req(B + 32'(4 * k));
            add(1'b0, 1'b1, NB, 1'b0, 0, 1'b0, 32'h0, 1'b1, B + 32'(4 * k));
        end
        r_req(B + 32'h10);
        add(1'b0, 1'b0, NB, 1'b0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
        r_hold(B + 32'h10);
        r_req(B + 32'h14);
`else
        // Reset, then zero-wait in-order fetch.
        r_rst(); r_rst();
        r_req(B); r_wait(); r_hold(B);
        // ID stalls five cycles on pc B+4.
        r_req(B + 32'h4); r_wait();
        for (int k = 0; k < 5; k++) r_hold(B + 32'h4, 1'b0);
        r_hold(B + 32'h4);
        r_req(B + 32'h8); r_wait(); r_hold(B + 32'h8);
        // Redirect in WAIT, response arrives two cycles later and is dropped.
        r_req(B + 32'hc, 1'b1, 2); r_wait(rd(B + 32'h100)); r_wait(); r_wait();
        r_req(B + 32'h100); r_wait(); r_hold(B + 32'h100);
        // Redirect in REQ while addr_ok is low for three cycles.
        r_req(B + 32'h104, 1'b0, 0, rd(B + 32'h200));
        r_req(B + 32'h104, 1'b0); r_req(B + 32'h104, 1'b0); r_req(B + 32'h104); r_wait();
        r_req(B + 32'h200); r_wait(); r_hold(B + 32'h200);
        // Redirect in HOLD beats ds_allowin.
        r_req(B + 32'h204); r_wait(); r_hold(B + 32'h204, 1'b1, rd(B + 32'h300), 1'b0);
        r_req(B + 32'h300); r_wait(); r_hold(B + 32'h300);
        // Redirect in the same cycle as addr_ok.
        r_req(B + 32'h304, 1'b1, 0, rd(B + 32'h400)); r_wait();
        r_req(B + 32'h400); r_wait(); r_hold(B + 32'h400);
        // Redirect in the same cycle as data_ok.
        r_req(B + 32'h404); r_wait(rd(B + 32'h500));
        r_req(B + 32'h500); r_wait(); r_hold(B + 32'h500);
        // Two redirects while pending: the later target wins.
        r_req(B + 32'h504, 1'b0, 0, rd(B + 32'h600));
        r_req(B + 32'h504, 1'b0, 0, rd(B + 32'h700));
        r_req(B + 32'h504); r_wait();
        r_req(B + 32'h700); r_wait();
        // br_taken without cancel is ignored.
        r_hold(B + 32'h700, 1'b1, {2'b01, B + 32'h800});
        // PC increment wraps.
        r_req(B + 32'h704); r_wait(rd(32'hffff_fffc));
        r_req(32'hffff_fffc); r_wait(); r_hold(32'hffff_fffc);
        r_req(32'h0); r_wait(); r_hold(32'h0);
        // Reset with a request outstanding.
        r_req(32'h4); r_rst();
        r_req(B); r_wait(); r_hold(B);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            reset      = tbl[i].rst;
            ds_allowin = tbl[i].alw;
            br_bus     = tbl[i].br;
            d_ok = m_pend && (m_cnt == 0);
            sram_if.inst_sram_data_ok = d_ok;
            sram_if.inst_sram_rdata   = d_ok ? f_inst(m_addr) : 32'h0;
            sram_if.inst_sram_addr_ok = 1'b0;
            #1;
            sram_if.inst_sram_addr_ok = tbl[i].aok && sram_if.inst_sram_req;
            #1;
            req  = sram_if.inst_sram_req;
            addr = sram_if.inst_sram_addr;

            check("req", i, {63'd0, req}, {63'd0, tbl[i].e_req});
            if (tbl[i].e_req) check("addr", i, {32'd0, addr}, {32'd0, tbl[i].e_addr});
            check("one_outstanding", i, {63'd0, req && m_pend}, 64'd0);
            check("valid", i, {63'd0, fs_to_ds_valid}, {63'd0, tbl[i].e_vld});
            if (tbl[i].e_vld)
                check("bus", i, fs_to_ds_bus, {f_inst(tbl[i].e_pc), tbl[i].e_pc});

            if (tbl[i].e_vld && tbl[i].alw)
                sb.push_back({f_inst(tbl[i].e_pc), tbl[i].e_pc});
            if (fs_to_ds_valid && tbl[i].alw) begin
                if (sb.size() == 0) begin
                    check("xfer_extra", i, 64'd1, 64'd0);
                end else begin
                    exp_bus = sb.pop_front();
                    check("xfer", i, fs_to_ds_bus, exp_bus);
                end
            end

            if (tbl[i].rst) begin
                m_pend = 1'b0;
            end else begin
                if (d_ok) m_pend = 1'b0;
                else if (m_pend) m_cnt--;
                if (req && sram_if.inst_sram_addr_ok) begin
                    m_pend = 1'b1;
                    m_addr = addr;
                    m_cnt  = tbl[i].dly;
                end
            end
        end

        check("sb_empty", 0, 64'(sb.size()), 64'd0);
        check("tie_wr", 0, {63'd0, sram_if.inst_sram_wr}, 64'd0);
        check("tie_size", 0, {62'd0, sram_if.inst_sram_size}, 64'd2);
        check("tie_wstrb", 0, {60'd0, sram_if.inst_sram_wstrb}, 64'd0);
        check("tie_wdata", 0, {32'd0, sram_if.inst_sram_wdata}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
